// File: rtl/judge_pkg.sv
// judge_pkg
//   Shared encodings for the keypad answer judge.
//   - ST_* : 2-bit FSM state encodings (COLLECT, JUDGE, PASS, FAIL)
//   - DIGIT_W : width of one keypad digit / one secret nibble
//   - CNT_W   : width of the wrong-attempt counter
package judge_pkg;

  localparam int DIGIT_W = 4;
  localparam int CNT_W   = 4;

  localparam logic [1:0] ST_COLLECT = 2'd0;
  localparam logic [1:0] ST_JUDGE   = 2'd1;
  localparam logic [1:0] ST_PASS    = 2'd2;
  localparam logic [1:0] ST_FAIL    = 2'd3;

endpackage

// File: rtl/answer_judge.sv
// answer_judge
//   Collects DIGITS keypad digits, compares them (most-significant nibble of
//   `secret` first) and judges each completed attempt. A correct attempt ends
//   the game in PASS; each wrong attempt pulses wrong_pulse for one cycle and
//   bumps wrong_count, and reaching MAX_WRONG ends the game in FAIL.
//
// Ports
//   clk          in   system clock, posedge
//   reset        in   asynchronous, active-low; clears all state
//   key_valid    in   one-cycle strobe, key_code carries a new digit
//   key_code     in   4-bit digit (any 4-bit value is compared as-is)
//   key_clear    in   one-cycle strobe, discard the partial entry
//   secret       in   4*DIGITS code, digit 0 in the MS nibble, stable during entry
//   wrong_pulse  out  one cycle per judged wrong attempt
//   wrong_count  out  wrong attempts so far, saturates at MAX_WRONG
//   digit_idx    out  digits accepted in the current attempt
//   pass         out  sticky, correct code entered
//   fail         out  sticky, MAX_WRONG wrong attempts reached
//   state_dbg    out  current FSM state (judge_pkg ST_* encoding)
//
// Key strobes carry no ready: the judge can take a digit on every cycle while
// in COLLECT. A strobe that lands in JUDGE, PASS or FAIL is dropped, and
// key_clear beats a key_valid presented in the same cycle.
module answer_judge
  import judge_pkg::*;
#(
  parameter int DIGITS    = 4,
  parameter int MAX_WRONG = 10
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      key_valid,
  input  logic [3:0]                key_code,
  input  logic                      key_clear,
  input  logic [4*DIGITS-1:0]       secret,
  output logic                      wrong_pulse,
  output logic [3:0]                wrong_count,
  output logic [2:0]                digit_idx,
  output logic                      pass,
  output logic                      fail,
  output logic [1:0]                state_dbg
);

  localparam logic [2:0]       LAST_IDX = 3'(DIGITS - 1);
  localparam logic [CNT_W-1:0] MAX_CNT  = CNT_W'(MAX_WRONG);

  logic [1:0]         state;
  logic               mismatch;
  logic [DIGIT_W-1:0] cur_digit;
  logic               key_bad;
  logic [CNT_W-1:0]   count_inc;

  // Secret digit that the next key is compared against, MS nibble first.
  always_comb begin
    cur_digit = secret[DIGIT_W*(DIGITS-1-int'({29'd0, digit_idx})) +: DIGIT_W];
    key_bad   = (key_code != cur_digit);
    count_inc = wrong_count + CNT_W'(1);
  end

  assign state_dbg = state;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= ST_COLLECT;
      mismatch    <= 1'b0;
      digit_idx   <= 3'd0;
      wrong_pulse <= 1'b0;
      wrong_count <= '0;
      pass        <= 1'b0;
      fail        <= 1'b0;
    end else begin
      // The pulse is only ever raised by the JUDGE branch below.
      wrong_pulse <= 1'b0;
      case (state)
        ST_COLLECT: begin
          if (key_clear) begin
            digit_idx <= 3'd0;
            mismatch  <= 1'b0;
          end else if (key_valid) begin
            // Mismatch accumulates across the whole attempt; the verdict is
            // deferred to JUDGE so every digit is always collected.
            mismatch <= mismatch | key_bad;
            if (digit_idx == LAST_IDX) begin
              digit_idx <= 3'd0;
              state     <= ST_JUDGE;
            end else begin
              digit_idx <= digit_idx + 3'd1;
            end
          end
        end

        ST_JUDGE: begin
          if (!mismatch) begin
            pass  <= 1'b1;
            state <= ST_PASS;
          end else begin
            wrong_pulse <= 1'b1;
            mismatch    <= 1'b0;
            // JUDGE is never entered once the count reached MAX_CNT, so the
            // increment cannot pass it; the guard keeps that explicit.
            if (wrong_count != MAX_CNT) begin
              wrong_count <= count_inc;
            end
            if (count_inc >= MAX_CNT) begin
              fail  <= 1'b1;
              state <= ST_FAIL;
            end else begin
              state <= ST_COLLECT;
            end
          end
        end

        // Terminal until reset: keys ignored, outputs hold.
        ST_PASS: state <= ST_PASS;
        ST_FAIL: state <= ST_FAIL;

        default: state <= ST_COLLECT;
      endcase
    end
  end

endmodule

// File: tb/tb_answer_judge.sv
// tb_answer_judge
//   Table of whole attempts with hand-derived outcomes, plus hand-written
//   sequences for clear, ignored keys, fail saturation and async reset.
//   Judgements ({pass, fail, wrong_count}) are queued when an attempt is
//   driven and popped by a monitor when the DUT signals a verdict.
module tb_answer_judge;

  logic        clk = 1'b0;
  logic        reset;
  logic        key_valid;
  logic [3:0]  key_code;
  logic        key_clear;
  logic [15:0] secret;
  logic        wrong_pulse;
  logic [3:0]  wrong_count;
  logic [2:0]  digit_idx;
  logic        pass;
  logic        fail;
  logic [1:0]  state_dbg;

  int checks = 0;
  int errors = 0;

  logic [5:0] exp_q[$];  // {pass, fail, wrong_count}

  typedef struct {
    logic        do_reset;
    logic [15:0] sec;
    logic [15:0] code;
    logic        exp_event;
    logic [3:0]  exp_count;
    logic        exp_pass;
    logic        exp_fail;
  } vec_t;

  vec_t vecs[9];

  answer_judge #(.DIGITS(4), .MAX_WRONG(10)) dut (
    .clk        (clk),
    .reset      (reset),
    .key_valid  (key_valid),
    .key_code   (key_code),
    .key_clear  (key_clear),
    .secret     (secret),
    .wrong_pulse(wrong_pulse),
    .wrong_count(wrong_count),
    .digit_idx  (digit_idx),
    .pass       (pass),
    .fail       (fail),
    .state_dbg  (state_dbg)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- compare helper ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- monitor / scoreboard ----------------
  logic prev_pass  = 1'b0;
  logic prev_pulse = 1'b0;
  logic [5:0] mon_exp;

  always @(negedge clk) begin
    if (prev_pulse === 1'b1) check("pulse_spacing", 32'(wrong_pulse), 32'd0);
    if (wrong_pulse === 1'b1 || (pass === 1'b1 && prev_pass !== 1'b1)) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_judge actual=%b%b_%0d expected=none at %0t",
                 pass, fail, wrong_count, $time);
      end else begin
        mon_exp = exp_q.pop_front();
        check("judge", 32'({pass, fail, wrong_count}), 32'(mon_exp));
      end
    end
    prev_pass  = pass;
    prev_pulse = wrong_pulse;
  end

  // ---------------- driver tasks (called at a negedge) ----------------
  task automatic send_key(input logic [3:0] d);
    key_code  = d;
    key_valid = 1'b1;
    @(negedge clk);
    key_valid = 1'b0;
  endtask

  task automatic attempt(input logic [15:0] c);
    for (int i = 0; i < 4; i++) send_key(c[15-4*i -: 4]);
  endtask

  // Bounded wait for the verdict: JUDGE cycle plus one.
  task automatic settle();
    repeat (2) @(negedge clk);
    check("sb_drain", 32'(exp_q.size()), 32'd0);
  endtask

  task automatic do_reset();
    key_valid = 1'b0;
    key_clear = 1'b0;
    reset     = 1'b0;
    @(negedge clk);
    reset     = 1'b1;
  endtask

  task automatic check_idle(input string name, input logic [3:0] cnt,
                            input logic p, input logic f);
    check({name, "_count"}, 32'(wrong_count), 32'(cnt));
    check({name, "_pass"},  32'(pass),        32'(p));
    check({name, "_fail"},  32'(fail),        32'(f));
    check({name, "_idx"},   32'(digit_idx),   32'd0);
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #200000;
    $display("FAIL watchdog actual=running expected=finished");
    $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------
  initial begin
    //          rst   secret    code      ev    cnt   pass  fail
    vecs[0] = '{1'b1, 16'h1234, 16'h1234, 1'b1, 4'd0, 1'b1, 1'b0};
    vecs[1] = '{1'b1, 16'h1234, 16'h1235, 1'b1, 4'd1, 1'b0, 1'b0};
    vecs[2] = '{1'b0, 16'h1234, 16'h1234, 1'b1, 4'd1, 1'b1, 1'b0};
    vecs[3] = '{1'b1, 16'h9999, 16'h9999, 1'b1, 4'd0, 1'b1, 1'b0};
    vecs[4] = '{1'b1, 16'hA0F5, 16'hA0F5, 1'b1, 4'd0, 1'b1, 1'b0};
    vecs[5] = '{1'b1, 16'h1234, 16'h0234, 1'b1, 4'd1, 1'b0, 1'b0};
    vecs[6] = '{1'b0, 16'h1234, 16'h1230, 1'b1, 4'd2, 1'b0, 1'b0};
    vecs[7] = '{1'b0, 16'h1234, 16'h1234, 1'b1, 4'd2, 1'b1, 1'b0};
    vecs[8] = '{1'b0, 16'h1234, 16'h5678, 1'b0, 4'd2, 1'b1, 1'b0};

    reset     = 1'b0;
    key_valid = 1'b0;
    key_clear = 1'b0;
    key_code  = 4'd0;
    secret    = 16'h1234;
    repeat (2) @(negedge clk);
    check("rst_pulse", 32'(wrong_pulse), 32'd0);
    check_idle("rst", 4'd0, 1'b0, 1'b0);
    reset = 1'b1;
    @(negedge clk);
    check_idle("post_rst", 4'd0, 1'b0, 1'b0);

    // Table-driven attempts.
    for (int i = 0; i < 9; i++) begin
      if (vecs[i].do_reset) do_reset();
      secret = vecs[i].sec;
      if (vecs[i].exp_event)
        exp_q.push_back({vecs[i].exp_pass, vecs[i].exp_fail, vecs[i].exp_count});
      attempt(vecs[i].code);
      settle();
      check_idle($sformatf("vec%0d", i), vecs[i].exp_count, vecs[i].exp_pass, vecs[i].exp_fail);
    end

    // Ten wrong attempts end in FAIL; further keys change nothing.
    do_reset();
    secret = 16'h1234;
    for (int i = 0; i < 10; i++) begin
      exp_q.push_back({1'b0, (i == 9), 4'(i + 1)});
      attempt(16'h1111);
      settle();
      check($sformatf("fail_seq%0d_count", i), 32'(wrong_count), 32'(i + 1));
    end
    attempt(16'h2222);
    settle();
    attempt(16'h1234);
    settle();
    check_idle("after_fail", 4'd10, 1'b0, 1'b1);

    // Clear discards a partial (wrong) entry without counting it.
    do_reset();
    secret = 16'h1234;
    send_key(4'd9);
    send_key(4'd9);
    check("partial_idx", 32'(digit_idx), 32'd2);
    key_clear = 1'b1;
    @(negedge clk);
    key_clear = 1'b0;
    check("clear_idx", 32'(digit_idx), 32'd0);
    exp_q.push_back({1'b1, 1'b0, 4'd0});
    attempt(16'h1234);
    settle();
    check_idle("clear_pass", 4'd0, 1'b1, 1'b0);

    // Clear together with a key drops that key.
    do_reset();
    send_key(4'd1);
    check("one_idx", 32'(digit_idx), 32'd1);
    key_clear = 1'b1;
    key_valid = 1'b1;
    key_code  = 4'd2;
    @(negedge clk);
    key_clear = 1'b0;
    key_valid = 1'b0;
    check("clear_valid_idx", 32'(digit_idx), 32'd0);
    exp_q.push_back({1'b1, 1'b0, 4'd0});
    attempt(16'h1234);
    settle();
    check_idle("clear_valid_pass", 4'd0, 1'b1, 1'b0);

    // Key during JUDGE is ignored; next wrong attempt right behind it gives
    // minimum pulse spacing; then a correct entry passes.
    do_reset();
    exp_q.push_back({1'b0, 1'b0, 4'd1});
    attempt(16'h1235);
    check("judge_state", 32'(state_dbg), 32'd1);
    send_key(4'd1);
    check("judge_ignored_idx", 32'(digit_idx), 32'd0);
    exp_q.push_back({1'b0, 1'b0, 4'd2});
    attempt(16'h1111);
    settle();
    exp_q.push_back({1'b1, 1'b0, 4'd2});
    attempt(16'h1234);
    settle();
    check_idle("judge_ign_pass", 4'd2, 1'b1, 1'b0);

    // Asynchronous reset mid-attempt.
    do_reset();
    send_key(4'd1);
    send_key(4'd2);
    #2 reset = 1'b0;
    #1 check("async_idx", 32'(digit_idx), 32'd0);
    @(negedge clk);
    reset = 1'b1;

    // Asynchronous reset after three wrong attempts.
    for (int i = 0; i < 3; i++) begin
      exp_q.push_back({1'b0, 1'b0, 4'(i + 1)});
      attempt(16'h4321);
      settle();
    end
    check("three_wrong", 32'(wrong_count), 32'd3);
    #2 reset = 1'b0;
    #1 check("async_count", 32'(wrong_count), 32'd0);
    check("async_pulse", 32'(wrong_pulse), 32'd0);
    @(negedge clk);
    reset = 1'b1;

    // Asynchronous reset during JUDGE: no pulse, nothing counted.
    attempt(16'h1235);
    #1 reset = 1'b0;
    #1 check("judge_rst_state", 32'(state_dbg), 32'd0);
    @(negedge clk);
    reset = 1'b1;
    settle();
    check_idle("judge_rst", 4'd0, 1'b0, 1'b0);

    exp_q.push_back({1'b1, 1'b0, 4'd0});
    attempt(16'h1234);
    settle();
    check_idle("final_pass", 4'd0, 1'b1, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
